// File: rtl/aes_round_ctrl_if.sv
// Purpose: control/status bundle between the AES round sequencer and its user.
// Latency: none (wires only).
// Backpressure: none; stall is a level input the sequencer may honour.
// Ports: start/abort/stall flow from master to slave; busy, load_state,
//        round_en, final_round, round_num, done, blk_cnt flow back.
interface aes_round_ctrl_if;
    logic       start;
    logic       abort;
    logic       stall;
    logic       busy;
    logic       load_state;
    logic       round_en;
    logic       final_round;
    logic [3:0] round_num;
    logic       done;
    logic [7:0] blk_cnt;

    modport master (
        output start, abort, stall,
        input  busy, load_state, round_en, final_round, round_num, done, blk_cnt
    );

    modport slave (
        input  start, abort, stall,
        output busy, load_state, round_en, final_round, round_num, done, blk_cnt
    );
endinterface

// File: rtl/aes_round_ctrl.sv
// Purpose: AES round sequencer (IDLE/LOAD/ROUND/FINAL/DONE), all outputs registered.
// Latency: start sampled -> done is NUM_ROUNDS+2 cycles with no stalls.
// Backpressure: stall (when AES_ROUND_CTRL_STALL_EN is defined) freezes LOAD/ROUND/FINAL.
// Ports: clk, n_rst (async active-low), bus (aes_round_ctrl_if.slave).
// Parameter NUM_ROUNDS: 10, 12 or 14.
// Macro AES_ROUND_CTRL_STALL_EN: when defined stall is honoured, otherwise ignored.
module aes_round_ctrl #(
    parameter int NUM_ROUNDS = 10
) (
    input  logic            clk,
    input  logic            n_rst,
    aes_round_ctrl_if.slave bus
);
    localparam logic [3:0] LAST_MID_ROUND = 4'(NUM_ROUNDS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ROUND = 3'd2,
        FINAL = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t     state;
    logic       busy_q;
    logic       load_q;
    logic       round_en_q;
    logic       final_q;
    logic       done_q;
    logic [3:0] round_num_q;
    logic [7:0] blk_cnt_q;
    logic       hold;

`ifdef AES_ROUND_CTRL_STALL_EN
    assign hold = bus.stall;
`else
    // Port kept for a uniform interface; sequencing never freezes.
    logic stall_unused;
    assign hold         = 1'b0;
    assign stall_unused = bus.stall;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            load_q      <= 1'b0;
            round_en_q  <= 1'b0;
            final_q     <= 1'b0;
            done_q      <= 1'b0;
            round_num_q <= 4'd0;
            blk_cnt_q   <= 8'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below; a held
            // (stalled) state therefore shows all strobes low.
            load_q     <= 1'b0;
            round_en_q <= 1'b0;
            final_q    <= 1'b0;
            done_q     <= 1'b0;
            if (bus.abort) begin
                state       <= IDLE;
                busy_q      <= 1'b0;
                round_num_q <= 4'd0;
            end else begin
                case (state)
                    // DONE shares IDLE's exit so a held start chains blocks.
                    IDLE, DONE: begin
                        round_num_q <= 4'd0;
                        if (bus.start) begin
                            state  <= LOAD;
                            busy_q <= 1'b1;
                            load_q <= 1'b1;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (!hold) begin
                            state       <= ROUND;
                            round_num_q <= 4'd1;
                            round_en_q  <= 1'b1;
                        end
                    end
                    ROUND: begin
                        if (!hold) begin
                            if (round_num_q == LAST_MID_ROUND) begin
                                state   <= FINAL;
                                final_q <= 1'b1;
                            end
                            round_num_q <= round_num_q + 4'd1;
                            round_en_q  <= 1'b1;
                        end
                    end
                    FINAL: begin
                        if (!hold) begin
                            state       <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            round_num_q <= 4'd0;
                            blk_cnt_q   <= blk_cnt_q + 8'd1;
                        end
                    end
                    default: begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        round_num_q <= 4'd0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_q;
    assign bus.load_state  = load_q;
    assign bus.round_en    = round_en_q;
    assign bus.final_round = final_q;
    assign bus.done        = done_q;
    assign bus.round_num   = round_num_q;
    assign bus.blk_cnt     = blk_cnt_q;
endmodule

// File: tb/tb_aes_round_ctrl.sv
// Purpose: self-checking bench for aes_round_ctrl (NUM_ROUNDS 10 and 14 instances).
// Latency: compares every cycle 1 time unit after the rising edge.
// Backpressure: exercises stall; expectations follow AES_ROUND_CTRL_STALL_EN.
module tb_aes_round_ctrl;
    localparam int NR = 10;
`ifdef AES_ROUND_CTRL_STALL_EN
    localparam bit STALL_EN = 1'b1;
`else
    localparam bit STALL_EN = 1'b0;
`endif

    logic clk   = 1'b0;
    logic n_rst = 1'b0;
    int vectors     = 0;
    int miscompares = 0;

    aes_round_ctrl_if bus ();
    aes_round_ctrl_if bus14 ();

    aes_round_ctrl #(.NUM_ROUNDS(NR)) u_dut   (.clk(clk), .n_rst(n_rst), .bus(bus));
    aes_round_ctrl #(.NUM_ROUNDS(14)) u_dut14 (.clk(clk), .n_rst(n_rst), .bus(bus14));

    always #5 clk = ~clk;

    // Reference model: position within a block. -1 idle, 0 load, 1..NR-1 middle
    // rounds, NR final round, NR+1 done. A stalled position shows no strobes.
    int m_pos     = -1;
    bit m_stalled = 1'b0;
    int m_blk     = 0;

    function automatic void model_reset();
        m_pos     = -1;
        m_stalled = 1'b0;
        m_blk     = 0;
    endfunction

    function automatic logic [16:0] exp_outs();
        logic b, l, e, f, d;
        logic [3:0] r;
        b = (m_pos >= 0) && (m_pos <= NR);
        l = (m_pos == 0) && !m_stalled;
        e = (m_pos >= 1) && (m_pos <= NR) && !m_stalled;
        f = (m_pos == NR) && !m_stalled;
        d = (m_pos == NR + 1);
        r = b ? 4'(m_pos) : 4'd0;
        return {b, l, e, f, d, r, 8'(m_blk)};
    endfunction

    function automatic logic [16:0] act_outs();
        return {bus.busy, bus.load_state, bus.round_en, bus.final_round, bus.done,
                bus.round_num, bus.blk_cnt};
    endfunction

    function automatic logic [16:0] act14_outs();
        return {bus14.busy, bus14.load_state, bus14.round_en, bus14.final_round, bus14.done,
                bus14.round_num, bus14.blk_cnt};
    endfunction

    // One clock: model advances on the same inputs the DUT samples.
    task automatic tick();
        @(posedge clk);
        if (!n_rst) begin
            model_reset();
        end else if (bus.abort) begin
            m_pos     = -1;
            m_stalled = 1'b0;
        end else if (m_pos >= 0 && m_pos <= NR && STALL_EN && bus.stall) begin
            m_stalled = 1'b1;
        end else begin
            m_stalled = 1'b0;
            if (m_pos < 0 || m_pos == NR + 1) m_pos = bus.start ? 0 : -1;
            else m_pos++;
            if (m_pos == NR + 1) m_blk = (m_blk + 1) % 256;
        end
        #1;
    endtask

    task automatic test_reset();
        bus.start = 0; bus.abort = 0; bus.stall = 0;
        bus14.start = 0; bus14.abort = 0; bus14.stall = 0;
        n_rst = 0;
        #3;
        vectors++;
        if (act_outs() !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_async: got %h want %h", act_outs(), 17'h0);
        end
        vectors++;
        if (act14_outs() !== 17'h0) begin
            miscompares++;
            $display("FAIL reset_async14: got %h want %h", act14_outs(), 17'h0);
        end
        tick();
        n_rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL reset_idle: got %h want %h", act_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_single_block();
        int done_cyc = -1;
        bus.start = 1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            if (c == 1) bus.start = 0;
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL single_c%0d: got %h want %h", c, act_outs(), exp_outs());
            end
            if (c == 1) begin
                vectors++;
                if (bus.load_state !== 1'b1) begin
                    miscompares++;
                    $display("FAIL single_load: got %b want 1", bus.load_state);
                end
            end
            if (bus.done === 1'b1 && done_cyc < 0) done_cyc = c;
        end
        vectors++;
        if (done_cyc != NR + 2) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want %0d", done_cyc, NR + 2);
        end
        vectors++;
        if (bus.blk_cnt !== 8'd1) begin
            miscompares++;
            $display("FAIL single_blk_cnt: got %0d want 1", bus.blk_cnt);
        end
    endtask

    task automatic test_back_to_back();
        int dones[$];
        int blk0 = m_blk;
        bus.start = 1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL b2b_c%0d: got %h want %h", c, act_outs(), exp_outs());
            end
            if (bus.done === 1'b1) dones.push_back(c);
            if (c == 13 || c == 25) begin
                vectors++;
                if (bus.load_state !== 1'b1) begin
                    miscompares++;
                    $display("FAIL b2b_reload_c%0d: got %b want 1", c, bus.load_state);
                end
            end
            if (c == 24) begin
                vectors++;
                if (bus.blk_cnt !== 8'(blk0 + 2)) begin
                    miscompares++;
                    $display("FAIL b2b_blk_cnt: got %0d want %0d", bus.blk_cnt, blk0 + 2);
                end
            end
        end
        bus.start = 0;
        vectors++;
        if (dones.size() != 2 || dones[0] != 12 || dones[1] != 24) begin
            miscompares++;
            $display("FAIL b2b_done_cycles: got %p want 12,24", dones);
        end
        for (int c = 0; c < 16; c++) begin
            tick();
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL b2b_drain: got %h want %h", act_outs(), exp_outs());
            end
        end
    endtask

    task automatic test_abort();
        bit found = 0;
        int blk0 = m_blk;
        int ndone = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.round_num === 4'd5) found = 1;
            else tick();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL abort_wait_round5: got timeout want round_num 5");
        end
        bus.abort = 1;
        tick();
        bus.abort = 0;
        vectors++;
        if ({bus.busy, bus.round_en, bus.round_num} !== 6'd0) begin
            miscompares++;
            $display("FAIL abort_idle: got busy=%b en=%b rn=%0d want 0,0,0",
                     bus.busy, bus.round_en, bus.round_num);
        end
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL abort_after: got %h want %h", act_outs(), exp_outs());
            end
        end
        vectors++;
        if (ndone != 0 || bus.blk_cnt !== 8'(blk0)) begin
            miscompares++;
            $display("FAIL abort_no_done: got dones=%0d blk=%0d want 0,%0d", ndone, bus.blk_cnt, blk0);
        end
        bus.abort = 1;
        bus.start = 1;
        tick();
        bus.abort = 0;
        bus.start = 0;
        vectors++;
        if ({bus.busy, bus.load_state} !== 2'b00) begin
            miscompares++;
            $display("FAIL abort_start_idle: got busy=%b load=%b want 0,0", bus.busy, bus.load_state);
        end
        tick();
    endtask

    task automatic test_stall();
        bit found = 0;
        int c = 1;
        int done_cyc = -1;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.round_num === 4'd4) found = 1;
            else begin tick(); c++; end
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL stall_wait_round4: got timeout want round_num 4");
        end
        bus.stall = 1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            c++;
            vectors++;
            if (bus.round_num !== (STALL_EN ? 4'd4 : 4'(4 + k)) || bus.round_en !== !STALL_EN) begin
                miscompares++;
                $display("FAIL stall_hold_%0d: got rn=%0d en=%b want rn=%0d en=%b", k, bus.round_num,
                         bus.round_en, STALL_EN ? 4 : 4 + k, !STALL_EN);
            end
        end
        bus.stall = 0;
        for (int i = 0; i < 20 && done_cyc < 0; i++) begin
            tick();
            c++;
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL stall_run: got %h want %h", act_outs(), exp_outs());
            end
            if (bus.done === 1'b1) done_cyc = c;
        end
        vectors++;
        if (done_cyc != (STALL_EN ? 15 : 12)) begin
            miscompares++;
            $display("FAIL stall_latency: got %0d want %0d", done_cyc, STALL_EN ? 15 : 12);
        end
        tick();
    endtask

    task automatic test_async_reset();
        bit found = 0;
        int ndone = 0;
        bus.start = 1;
        tick();
        bus.start = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (bus.final_round === 1'b1) found = 1;
            else tick();
        end
        vectors++;
        if (!found) begin
            miscompares++;
            $display("FAIL areset_wait_final: got timeout want final_round");
        end
        #2 n_rst = 0;
        #1;
        vectors++;
        if (act_outs() !== 17'h0) begin
            miscompares++;
            $display("FAIL areset_mid_final: got %h want %h", act_outs(), 17'h0);
        end
        model_reset();
        tick();
        n_rst = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (bus.done === 1'b1) ndone++;
        end
        vectors++;
        if (ndone != 0 || act_outs() !== exp_outs()) begin
            miscompares++;
            $display("FAIL areset_quiet: got dones=%0d outs=%h want 0,%h", ndone, act_outs(), exp_outs());
        end
        bus.start = 1;
        tick();
        bus.start = 0;
        vectors++;
        if (bus.load_state !== 1'b1 || act_outs() !== exp_outs()) begin
            miscompares++;
            $display("FAIL areset_fresh_load: got %h want %h", act_outs(), exp_outs());
        end
        for (int i = 0; i < 14; i++) tick();
    endtask

    task automatic test_wrap();
        int ndone = 0;
        #2 n_rst = 0;
        #2 n_rst = 1;
        model_reset();
        bus.start = 1;
        for (int i = 0; i < 256 * (NR + 2) + 20 && ndone < 256; i++) begin
            tick();
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL wrap_cycle%0d: got %h want %h", i, act_outs(), exp_outs());
            end
            if (bus.done === 1'b1) begin
                ndone++;
                if (ndone == 255) begin
                    vectors++;
                    if (bus.blk_cnt !== 8'd255) begin
                        miscompares++;
                        $display("FAIL wrap_255: got %0d want 255", bus.blk_cnt);
                    end
                end
                if (ndone == 256) bus.start = 0;
            end
        end
        vectors++;
        if (ndone != 256 || bus.blk_cnt !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_to_zero: got dones=%0d blk=%0d want 256,0", ndone, bus.blk_cnt);
        end
        tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2000; i++) begin
            bus.start = ($urandom_range(0, 9) < 3);
            bus.abort = ($urandom_range(0, 49) == 0);
            bus.stall = ($urandom_range(0, 4) == 0);
            tick();
            vectors++;
            if (act_outs() !== exp_outs()) begin
                miscompares++;
                $display("FAIL random_%0d: got %h want %h", i, act_outs(), exp_outs());
            end
            vectors++;
            if ($countones({bus.load_state, bus.round_en, bus.done}) > 1) begin
                miscompares++;
                $display("FAIL random_onehot_%0d: got %b want at most one",
                         i, {bus.load_state, bus.round_en, bus.done});
            end
        end
        bus.start = 0;
        bus.stall = 0;
        bus.abort = 1;
        tick();
        bus.abort = 0;
    endtask

    task automatic test_rounds14();
        int done_cyc = -1;
        int bad_rn = 0;
        bus14.start = 1;
        for (int c = 1; c <= 18; c++) begin
            tick();
            if (c == 1) bus14.start = 0;
            if (bus14.done === 1'b1 && done_cyc < 0) done_cyc = c;
            vectors++;
            if ((bus14.round_num === 4'd14) !== (bus14.final_round === 1'b1) || bus14.round_num > 4'd14) begin
                bad_rn++;
                miscompares++;
                $display("FAIL r14_final_c%0d: got rn=%0d final=%b want rn14 only with final",
                         c, bus14.round_num, bus14.final_round);
            end
            if (c >= 2 && c <= 14) begin
                vectors++;
                if (bus14.round_num !== 4'(c - 1) || bus14.round_en !== 1'b1) begin
                    miscompares++;
                    $display("FAIL r14_round_c%0d: got rn=%0d en=%b want %0d,1",
                             c, bus14.round_num, bus14.round_en, c - 1);
                end
            end
        end
        vectors++;
        if (done_cyc != 16) begin
            miscompares++;
            $display("FAIL r14_latency: got %0d want 16", done_cyc);
        end
    endtask

    initial begin
        test_reset();
        test_single_block();
        test_back_to_back();
        test_abort();
        test_stall();
        test_async_reset();
        test_wrap();
        test_random();
        test_rounds14();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 The block SHALL have one parameter: NUM_ROUNDS, default 10, number of AES rounds; legal values are 10, 12 and 14 only.
REQ-002 clk  input  1  system clock; all state updates on the rising edge.
REQ-003 n_rst  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to encrypt one block; sampled on each rising edge.
REQ-005 abort  input  1  cancels any block in progress.
REQ-006 stall  input  1  freezes round sequencing (see Configuration).
REQ-007 busy  output  1  high in LOAD, ROUND and FINAL.
REQ-008 load_state  output  1  loads the plaintext and key into the datapath.
REQ-009 round_en  output  1  enables the datapath round logic this cycle.
REQ-010 final_round  output  1  selects the last round (no MixColumns).
REQ-011 round_num  output  4  current round index, also the round-key select.
REQ-012 done  output  1  one-cycle pulse when the ciphertext is valid.
REQ-013 blk_cnt  output  8  count of completed blocks.

Function
REQ-014 The block SHALL be a Moore FSM with states IDLE, LOAD, ROUND, FINAL and DONE; all outputs SHALL be registered.
REQ-015 IDLE: start=1 and abort=0 SHALL go to LOAD on the next edge; otherwise the state SHALL stay IDLE.
REQ-016 LOAD SHALL last one cycle with load_state=1 and round_num=0, then go to ROUND with round_num=1.
REQ-017 ROUND: round_en=1 each cycle; round_num SHALL increment by 1 per cycle until NUM_ROUNDS-1, then go to FINAL.
REQ-018 FINAL SHALL last one cycle with round_en=1, final_round=1 and round_num=NUM_ROUNDS, then go to DONE.
REQ-019 DONE SHALL last exactly one cycle with done=1 and busy=0, and SHALL increment blk_cnt.
REQ-020 From DONE, start=1 SHALL go directly to LOAD (back-to-back blocks); otherwise the FSM SHALL go to IDLE.
REQ-021 Latency from start sampled to done high SHALL be NUM_ROUNDS+2 cycles when there are no stalls (12 cycles for NUM_ROUNDS=10).
REQ-022 start SHALL be ignored while busy=1.
REQ-023 abort=1 in any state SHALL force IDLE on the next edge, with round_num=0 and all strobes low; blk_cnt is not incremented.
REQ-024 abort SHALL take priority over start and stall in the same cycle.
REQ-025 blk_cnt SHALL wrap from 255 to 0 with no flag.
REQ-026 round_num SHALL be 0 in IDLE and DONE, and SHALL never exceed NUM_ROUNDS.
REQ-027 Only one of load_state, round_en and done SHALL be high in any cycle.

Reset
REQ-028 With n_rst=0 the state SHALL be IDLE, and busy, load_state, round_en, final_round, done, round_num and blk_cnt SHALL all be 0, immediately and without waiting for a clock edge.
REQ-029 Reset mid-block SHALL abandon the block with no done pulse; the first start after reset is released SHALL begin a fresh LOAD.

Configuration
REQ-030 Macro AES_ROUND_CTRL_STALL_EN SHALL control whether stall is honoured.
REQ-031 With the macro defined, stall=1 in LOAD, ROUND or FINAL SHALL hold the state and round_num and force load_state, round_en and final_round to 0.
REQ-032 With the macro defined, the strobes SHALL resume with unchanged round_num on the cycle after stall falls; stall SHALL have no effect in IDLE or DONE.
REQ-033 Without the macro, the stall port SHALL remain present but be ignored, and latency SHALL be fixed per REQ-021.

Verification
REQ-034 Reset, then start pulse with NUM_ROUNDS=10 -> load_state at cycle 1; round_num 1..9 on cycles 2..10; final_round at cycle 11; done at cycle 12; blk_cnt=1.
REQ-035 start held high for 30 cycles -> done at cycles 12 and 24, with LOAD the cycle after each done; blk_cnt=2 after the second done.
REQ-036 abort in ROUND at round_num=5 -> IDLE on the next cycle, round_num=0, no done, blk_cnt unchanged; abort and start together in IDLE -> stays IDLE.
REQ-037 With AES_ROUND_CTRL_STALL_EN: stall high 3 cycles at round_num=4 -> round_num holds 4, round_en=0, done at cycle 15; without the macro, the same stimulus -> done at cycle 12.
REQ-038 n_rst pulled low mid-FINAL -> all outputs 0 asynchronously; 256 completed blocks -> blk_cnt wraps to 0.
REQ-039 NUM_ROUNDS=14 -> round_num reaches 14 only in FINAL; done 16 cycles after start.
